dpram_tdm: RTL and testbench
============================

DPRAM_TDM -- requirements
Module: dpram_tdm

Interface
REQ-001 SHALL have parameter AW, default 8, memory address width in bits.
REQ-002 SHALL have parameter DW, default 16, memory data width in bits.
REQ-003 SHALL have port clk  input  1  single clock (the doubled clock clkx2 in system use); all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have, per port P in {a, b}, the following ports:
- P_req  input  1  access request.
- P_we  input  1  1 = write, 0 = read.
- P_addr  input  AW  address.
- P_wdata  input  DW  write data.
- P_ack  output  1  request accepted this cycle.
- P_rvalid  output  1  read data valid.
- P_rdata  output  DW  read data.
REQ-006 SHALL have port mem_en  output  1  single-port SRAM enable.
REQ-007 SHALL have port mem_we  output  1  SRAM write enable.
REQ-008 SHALL have port mem_addr  output  AW  SRAM address.
REQ-009 SHALL have port mem_wdata  output  DW  SRAM write data.
REQ-010 SHALL have port mem_rdata  input  DW  SRAM read data, valid one cycle after a read enable.

Function
REQ-011 SHALL keep a 1-bit slot register:
- reset to 0;
- toggles every cycle when rst_n=1.
- Slot 0 is owned by port A; slot 1 is owned by port B.
REQ-012 Arbitration SHALL follow these rules in each cycle:
- If the slot owner has req=1, the owner is granted.
- Otherwise, if the other port has req=1, the other port is granted (work-conserving steal).
- Otherwise there is no grant.
REQ-013 At most one grant SHALL occur per cycle; the granted port's ack is driven high combinationally in the same cycle.
REQ-014 The non-granted port's ack SHALL be low.
REQ-015 On a grant, mem_en=1, and mem_we/mem_addr/mem_wdata SHALL equal the granted port's we/addr/wdata, combinationally.
REQ-016 With no grant:
- mem_en=0 and mem_we=0;
- mem_addr and mem_wdata are don't-care but SHALL be driven to 0.
REQ-017 A requester SHALL hold req/we/addr/wdata stable until ack; once req is asserted, the block SHALL ack it within 2 cycles.
REQ-018 A port with req held high after ack SHALL be treated as issuing a new request.
REQ-019 On a granted read, the block SHALL register the owner tag. In the next cycle:
- the owner's rvalid=1;
- the owner's rdata=mem_rdata.
- The other port's rvalid=0.
REQ-020 P_rdata SHALL be 0 whenever P_rvalid=0.
REQ-021 Granted writes SHALL produce no rvalid.
REQ-022 Back-to-back reads SHALL sustain one rvalid per cycle (full throughput); the read tag is a single-stage pipeline register.
REQ-023 When both ports request in the same cycle, only the slot owner SHALL be acked. The loser is acked in the next cycle, when it becomes slot owner.
REQ-024 A write granted in cycle N followed by a read of the same address granted in cycle N+1 SHALL return the written data, relying on SRAM write-then-read ordering (no forwarding logic).

Reset
REQ-025 While rst_n=0 at a clock edge, the block SHALL reset its registers:
- slot register reset to 0;
- read tag cleared.
REQ-026 While rst_n=0, all outputs SHALL be low or zero: acks, rvalids, rdata, mem_en, mem_we, mem_addr, mem_wdata.
REQ-027 Requests presented during reset SHALL be ignored and not acked.
REQ-028 If reset asserts in the cycle after a read grant, that read's rvalid SHALL be suppressed.
REQ-029 On the first cycle after reset release, slot=0, so port A SHALL have priority.

Verification
REQ-030 Directed scenario, A-only: reset, then A reads addr 0x10 every cycle -> A acked every cycle (owns slot 0, steals slot 1); a_rvalid high from the second cycle onward; b_ack=0 throughout.
REQ-031 Directed scenario, contention: A and B both request from the first post-reset cycle -> a_ack in cycles 0, 2, 4, ...; b_ack in cycles 1, 3, 5, ...; never both high.
REQ-032 Directed scenario, write/read: A writes 0xBEEF to 0x05; B reads 0x05 in the next slot -> b_rvalid=1 with b_rdata=0xBEEF one cycle after b_ack; a_rvalid stays 0.
REQ-033 Directed scenario, late request: B raises req in a slot-0 cycle while A is idle -> b_ack in the same cycle (steal); mem_addr equals b_addr.
REQ-034 Directed scenario, reset mid-read: A read acked, then rst_n=0 on the next edge -> a_rvalid stays 0; after release, slot=0 and all outputs are 0 until a new request.
REQ-035 Directed scenario, random stress: random req/we/addr on both ports against a reference memory model -> all read data matches; every request is acked within 2 cycles; mem_en=1 if and only if exactly one ack is high.

Source files
------------

// File: rtl/dpram_tdm.sv
// Two request ports time-multiplexed onto one single-port SRAM.
// Alternating slot ownership; an idle owner's slot may be stolen.
module dpram_tdm #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic r_slot;
  logic r_rd_a;
  logic r_rd_b;
  logic w_a_gnt;
  logic w_b_gnt;

  // Owner wins; the other port only gets the slot when the owner is idle.
  always_comb begin
    w_a_gnt = rst_n & a_req & (~r_slot | ~b_req);
    w_b_gnt = rst_n & b_req & (r_slot | ~a_req);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_slot <= 1'b0;
      r_rd_a <= 1'b0;
      r_rd_b <= 1'b0;
    end else begin
      r_slot <= ~r_slot;
      r_rd_a <= w_a_gnt & ~a_we;
      r_rd_b <= w_b_gnt & ~b_we;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      w_a_gnt: begin
        mem_en    = 1'b1;
        mem_we    = a_we;
        mem_addr  = a_addr;
        mem_wdata = a_wdata;
      end
      w_b_gnt: begin
        mem_en    = 1'b1;
        mem_we    = b_we;
        mem_addr  = b_addr;
        mem_wdata = b_wdata;
      end
      default: ;
    endcase
  end

  // Reset gates the read return so a read granted just before reset dies.
  assign a_ack    = w_a_gnt;
  assign b_ack    = w_b_gnt;
  assign a_rvalid = rst_n & r_rd_a;
  assign b_rvalid = rst_n & r_rd_b;
  assign a_rdata  = {DW{a_rvalid}} & mem_rdata;
  assign b_rdata  = {DW{b_rvalid}} & mem_rdata;

endmodule

// File: tb/tb_dpram_tdm.sv
// Bench for dpram_tdm: SRAM model plus a transaction-level reference.
// Directed scenarios followed by random two-port stress.
module tb_dpram_tdm;
  localparam int AW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic a_ack, a_rvalid, b_ack, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_chk = 0;
  int n_bad = 0;

  logic [DW-1:0] sram [256] = '{default: '0};
  logic [DW-1:0] refm [256] = '{default: '0};
  logic [DW-1:0] r_mrd = '0;

  int k = 0;
  bit erv_a = 0, erv_b = 0;
  logic [DW-1:0] eda = '0, edb = '0;
  int pa = 0, pb = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else r_mrd <= sram[mem_addr];
    end
  end
  assign mem_rdata = r_mrd;

  dpram_tdm #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_ack(a_ack),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_ack(b_ack),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (k=%0d t=%0t)",
               tag, got, exp, k, $time);
    end
  endtask

  // One clock cycle: drive after negedge, check, advance the model.
  task automatic step(input logic rn,
                      input logic ar, input logic aw,
                      input logic [AW-1:0] aa,
                      input logic [DW-1:0] ad,
                      input logic br, input logic bw,
                      input logic [AW-1:0] ba,
                      input logic [DW-1:0] bd);
    bit ga, gb;
    @(negedge clk);
    rst_n = rn;
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    #1;
    if (!rn) begin
      check("rst_ctl", {26'd0, a_ack, b_ack, a_rvalid,
                        b_rvalid, mem_en, mem_we}, 0);
      check("rst_dat", {16'd0, a_rdata | b_rdata | mem_wdata}, 0);
      check("rst_adr", {24'd0, mem_addr}, 0);
      k = 0; erv_a = 0; erv_b = 0; pa = 0; pb = 0;
      return;
    end
    // owner of this cycle is the parity of cycles since reset
    ga = ar && ((k % 2) == 0 || !br);
    gb = br && ((k % 2) == 1 || !ar);
    check("a_ack", {31'd0, a_ack}, {31'd0, ga});
    check("b_ack", {31'd0, b_ack}, {31'd0, gb});
    check("mem_en", {31'd0, mem_en}, {31'd0, ga | gb});
    check("en_xor", {31'd0, mem_en}, {31'd0, a_ack ^ b_ack});
    if (ga) begin
      check("mwe", {31'd0, mem_we}, {31'd0, aw});
      check("maddr", {24'd0, mem_addr}, {24'd0, aa});
      if (aw) check("mwd", {16'd0, mem_wdata}, {16'd0, ad});
    end else if (gb) begin
      check("mwe", {31'd0, mem_we}, {31'd0, bw});
      check("maddr", {24'd0, mem_addr}, {24'd0, ba});
      if (bw) check("mwd", {16'd0, mem_wdata}, {16'd0, bd});
    end else begin
      check("idle_mem", {7'd0, mem_we, mem_addr, mem_wdata}, 0);
    end
    check("a_rv", {31'd0, a_rvalid}, {31'd0, erv_a});
    check("a_rd", {16'd0, a_rdata}, erv_a ? {16'd0, eda} : 0);
    check("b_rv", {31'd0, b_rvalid}, {31'd0, erv_b});
    check("b_rd", {16'd0, b_rdata}, erv_b ? {16'd0, edb} : 0);
    // a pending request may wait at most one cycle
    if (ar && !a_ack) pa++; else pa = 0;
    if (br && !b_ack) pb++; else pb = 0;
    check("a_wait", pa, (pa > 1) ? 1 : pa);
    check("b_wait", pb, (pb > 1) ? 1 : pb);
    erv_a = ga && !aw;
    erv_b = gb && !bw;
    if (erv_a) eda = refm[aa];
    if (erv_b) edb = refm[ba];
    if (ga && aw) refm[aa] = ad;
    if (gb && bw) refm[ba] = bd;
    k++;
  endtask

  task automatic idle(input logic rn);
    step(rn, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++)
      step(0, 1, $urandom_range(0, 1), 8'($urandom),
           16'($urandom), 1, $urandom_range(0, 1),
           8'($urandom), 16'($urandom));
  endtask

  initial begin
    bit  pend_a = 0, pend_b = 0;
    logic       swa = 0, swb = 0;
    logic [7:0] saa = 0, sab = 0;
    logic [15:0] sda = 0, sdb = 0;

    do_reset();
    // A alone reads every cycle
    for (int i = 0; i < 6; i++) step(1, 1, 0, 8'h10, 0, 0, 0, 0, 0);
    do_reset();
    // both contend from the first cycle
    for (int i = 0; i < 6; i++)
      step(1, 1, 0, 8'h20, 0, 1, 0, 8'h21, 0);
    do_reset();
    // write then read same address from the other port
    step(1, 1, 1, 8'h05, 16'hBEEF, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 8'h05, 0);
    idle(1);
    check("wr_rd_val", {16'd0, b_rdata}, 32'h0000BEEF);
    check("wr_rd_arv", {31'd0, a_rvalid}, 0);
    // B steals a slot-0 cycle (k is 3 here, so idle once more)
    idle(1);
    step(1, 0, 0, 0, 0, 1, 0, 8'h33, 0);
    check("steal_adr", {24'd0, mem_addr}, 32'h33);
    idle(1);
    // reset arrives right after a granted read
    do_reset();
    step(1, 1, 0, 8'h05, 0, 0, 0, 0, 0);
    idle(0);
    for (int i = 0; i < 3; i++) idle(1);
    // random stress
    for (int c = 0; c < 3000; c++) begin
      if (!pend_a && $urandom_range(0, 9) < 7) begin
        pend_a = 1; swa = $urandom_range(0, 1);
        saa = 8'($urandom_range(0, 15)); sda = 16'($urandom);
      end
      if (!pend_b && $urandom_range(0, 9) < 7) begin
        pend_b = 1; swb = $urandom_range(0, 1);
        sab = 8'($urandom_range(0, 15)); sdb = 16'($urandom);
      end
      step(1, pend_a, swa, saa, sda, pend_b, swb, sab, sdb);
      if (a_ack) pend_a = 0;
      if (b_ack) pend_b = 0;
    end
    idle(1);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
